ahbl_arbiter_2m: RTL

AHBL_ARBITER_2M -- requirements
Module: ahbl_arbiter_2m

---
 rtl/ahbl_pkg.sv | 25 ++
 rtl/ahbl_master_port.sv | 40 ++++
 rtl/ahbl_arbiter_2m.sv | 116 +++++++++++
 3 files changed

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions for the two-master arbiter slice.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic M0 = 1'b0;   // CPU
    localparam logic M1 = 1'b1;   // DMAC

    // Address-phase request as seen from one master.
    typedef struct packed {
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [2:0]  hsize;
    } ahbl_req_t;

    // True while a master is inside a burst (SEQ or BUSY); ownership must not move.
    function automatic logic is_burst_cont(input logic [1:0] htrans);
        return (htrans == HTRANS_SEQ) || (htrans == HTRANS_BUSY);
    endfunction

endpackage

// File: rtl/ahbl_master_port.sv
// Per-master pending stage: holds an address phase the master believes was
// accepted but which the shared bus did not take, and presents the effective request.
module ahbl_master_port
    import ahbl_pkg::*;
(
    input  logic      HCLK,
    input  logic      HRESETn,
    input  ahbl_req_t live_req,     // address/control straight from the master
    input  logic      port_hready,  // HREADY as returned to this master
    input  logic      bus_hready,   // HREADY of the shared bus
    input  logic      granted,      // this master owns the address phase now
    output logic      pend_valid,
    output ahbl_req_t eff_req
);

    ahbl_req_t pend_req;

    // Capture an unserved transfer the master sees as accepted; release it once the bus takes it.
    // A transfer granted while the bus is stalled is captured too, otherwise it would be lost.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_valid <= 1'b0;
            pend_req   <= '0;
        end else if (granted && bus_hready) begin
            pend_valid <= 1'b0;
        end else if (!pend_valid && port_hready && live_req.htrans[1]) begin
            pend_valid <= 1'b1;
            pend_req   <= live_req;
        end
    end

    // The pending copy takes precedence over whatever the stalled master now drives.
    always_comb begin
        eff_req = live_req;
        if (pend_valid) begin
            eff_req = pend_req;
        end
    end

endmodule

// File: rtl/ahbl_arbiter_2m.sv
// Two-master AHB-Lite arbiter: CPU (M0) and DMAC (M1) share one bus toward the
// slave splitter. Round-robin on contention, bursts are never split.
module ahbl_arbiter_2m
    import ahbl_pkg::*;
#(
    parameter int M1_FIRST = 1
)
(
    input  logic        HCLK,
    input  logic        HRESETn,

    input  logic [31:0] M0_HADDR,
    input  logic [1:0]  M0_HTRANS,
    input  logic        M0_HWRITE,
    input  logic [2:0]  M0_HSIZE,
    input  logic [31:0] M0_HWDATA,
    output logic [31:0] M0_HRDATA,
    output logic        M0_HREADY,

    input  logic [31:0] M1_HADDR,
    input  logic [1:0]  M1_HTRANS,
    input  logic        M1_HWRITE,
    input  logic [2:0]  M1_HSIZE,
    input  logic [31:0] M1_HWDATA,
    output logic [31:0] M1_HRDATA,
    output logic        M1_HREADY,

    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY
);

    // Last owner starts as the master that should lose the first contention,
    // so "grant the one not last granted" yields the configured winner.
    localparam logic RESET_OWNER = (M1_FIRST != 0) ? M0 : M1;

    ahbl_req_t   live_req [2];
    ahbl_req_t   eff_req  [2];
    ahbl_req_t   owner_req;
    logic [1:0]  pend_valid;
    logic [1:0]  requesting;
    logic [1:0]  granted;
    logic [1:0]  port_hready;

    logic        aowner;          // address-phase owner (combinational)
    logic        last_owner_reg;  // also serves as the contention toggle
    logic        downer_reg;      // data-phase owner
    logic        dvalid_reg;      // a real transfer is in its data phase

    assign live_req[0] = '{haddr: M0_HADDR, htrans: M0_HTRANS, hwrite: M0_HWRITE, hsize: M0_HSIZE};
    assign live_req[1] = '{haddr: M1_HADDR, htrans: M1_HTRANS, hwrite: M1_HWRITE, hsize: M1_HSIZE};

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        ahbl_master_port u_port (
            .HCLK        (HCLK),
            .HRESETn     (HRESETn),
            .live_req    (live_req[gi]),
            .port_hready (port_hready[gi]),
            .bus_hready  (HREADY),
            .granted     (granted[gi]),
            .pend_valid  (pend_valid[gi]),
            .eff_req     (eff_req[gi])
        );

        assign requesting[gi] = eff_req[gi].htrans[1];
        assign granted[gi]    = (aowner == 1'(gi));
        // The data-phase owner sees the slave's HREADY; anyone else is stalled only while pending.
        assign port_hready[gi] = (dvalid_reg && (downer_reg == 1'(gi))) ? HREADY : ~pend_valid[gi];
    end

    // Pick the address-phase owner: burst hold, then round-robin, then single requester.
    always_comb begin
        aowner = last_owner_reg;
        if (is_burst_cont(eff_req[last_owner_reg].htrans)) begin
            aowner = last_owner_reg;
        end else if (requesting[0] && requesting[1]) begin
            aowner = ~last_owner_reg;
        end else if (requesting[0]) begin
            aowner = M0;
        end else if (requesting[1]) begin
            aowner = M1;
        end
    end

    // Advance grant history and data-phase ownership only when the slave is ready.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            last_owner_reg <= RESET_OWNER;
            downer_reg     <= M0;
            dvalid_reg     <= 1'b0;
        end else if (HREADY) begin
            last_owner_reg <= aowner;
            downer_reg     <= aowner;
            dvalid_reg     <= requesting[aowner];
        end
    end

    assign owner_req = eff_req[aowner];

    assign HADDR  = owner_req.haddr;
    assign HWRITE = owner_req.hwrite;
    assign HSIZE  = owner_req.hsize;
    // Masters may still drive NONSEQ while reset is held; keep the bus idle regardless.
    assign HTRANS = (HRESETn && requesting[aowner]) ? owner_req.htrans : HTRANS_IDLE;

    assign HWDATA    = (downer_reg == M1) ? M1_HWDATA : M0_HWDATA;
    assign M0_HRDATA = HRDATA;
    assign M1_HRDATA = HRDATA;
    assign M0_HREADY = port_hready[0];
    assign M1_HREADY = port_hready[1];

endmodule
